// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. All outputs are registered and
// decoded from the next (row,col), so every output describes the same pixel.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned ROW_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;

  logic             w_col_last;
  logic             w_row_last;
  logic [COL_W-1:0] w_col_nxt;
  logic [ROW_W-1:0] w_row_nxt;
  logic             w_hsync_nxt;
  logic             w_vsync_nxt;
  logic             w_active_nxt;

  // Next raster position and its decode; comparisons done at 32 bits
  always_comb begin
    w_col_last   = (32'(col) == H_TOTAL - 1);
    w_row_last   = (32'(row) == V_TOTAL - 1);
    w_col_nxt    = w_col_last ? '0 : col + COL_W'(1);
    w_row_nxt    = row;
    if (w_col_last) begin
      w_row_nxt = w_row_last ? '0 : row + ROW_W'(1);
    end
    w_hsync_nxt  = ((32'(w_col_nxt) >= H_SYNC_BEG) && (32'(w_col_nxt) < H_SYNC_END))
                   ? H_SYNC_POL : ~H_SYNC_POL;
    w_vsync_nxt  = ((32'(w_row_nxt) >= V_SYNC_BEG) && (32'(w_row_nxt) < V_SYNC_END))
                   ? V_SYNC_POL : ~V_SYNC_POL;
    w_active_nxt = (32'(w_col_nxt) < H_ACTIVE) && (32'(w_row_nxt) < V_ACTIVE);
  end

  // Pulses are cleared on idle ce cycles; everything else holds
  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      active      <= 1'b1;
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      col         <= w_col_nxt;
      row         <= w_row_nxt;
      active      <= w_active_nxt;
      hsync       <= w_hsync_nxt;
      vsync       <= w_vsync_nxt;
      line_start  <= w_col_last;
      frame_start <= w_col_last && w_row_last;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every cycle against a
// tick-count raster model, plus directed literal checks.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [15:0] col;
    logic [15:0] row;
    logic hs, vs, act, ls, fs;
  } obs_t;

  typedef struct {
    int unsigned ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } cfg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v;
  logic [2:0] ce_v;

  logic [9:0] d0_col, d0_row;
  logic [3:0] d1_col, d2_col;
  logic [2:0] d1_row, d2_row;
  logic d0_hs, d0_vs, d0_act, d0_ls, d0_fs;
  logic d1_hs, d1_vs, d1_act, d1_ls, d1_fs;
  logic d2_hs, d2_vs, d2_act, d2_ls, d2_fs;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst_v[0]), .ce(ce_v[0]), .col(d0_col), .row(d0_row),
    .hsync(d0_hs), .vsync(d0_vs), .active(d0_act),
    .line_start(d0_ls), .frame_start(d0_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .COL_W(4), .ROW_W(3)
  ) u_small (
    .clk(clk), .rst(rst_v[1]), .ce(ce_v[1]), .col(d1_col), .row(d1_row),
    .hsync(d1_hs), .vsync(d1_vs), .active(d1_act),
    .line_start(d1_ls), .frame_start(d1_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(0), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(0), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .COL_W(4), .ROW_W(3)
  ) u_zero (
    .clk(clk), .rst(rst_v[2]), .ce(ce_v[2]), .col(d2_col), .row(d2_row),
    .hsync(d2_hs), .vsync(d2_vs), .active(d2_act),
    .line_start(d2_ls), .frame_start(d2_fs)
  );

  cfg_t        cfg [3];
  int unsigned m_t [3];
  bit          m_rst [3];
  bit          m_ce [3];
  bit          m_valid [3];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic obs_t cur(input int k);
    case (k)
      0:       return {16'(d0_col), 16'(d0_row), d0_hs, d0_vs, d0_act, d0_ls, d0_fs};
      1:       return {16'(d1_col), 16'(d1_row), d1_hs, d1_vs, d1_act, d1_ls, d1_fs};
      default: return {16'(d2_col), 16'(d2_row), d2_hs, d2_vs, d2_act, d2_ls, d2_fs};
    endcase
  endfunction

  // Position is the number of ce ticks since reset, folded by the raster size
  function automatic obs_t model(input int k);
    obs_t e;
    int unsigned ht, vt, c, r, hb, vb;
    ht = cfg[k].ha + cfg[k].hf + cfg[k].hs + cfg[k].hb;
    vt = cfg[k].va + cfg[k].vf + cfg[k].vs + cfg[k].vb;
    if (m_rst[k]) begin
      e = {16'd0, 16'd0, ~cfg[k].hp, ~cfg[k].vp, 1'b1, 1'b0, 1'b0};
      return e;
    end
    c = m_t[k] % ht;
    r = (m_t[k] / ht) % vt;
    hb = cfg[k].ha + cfg[k].hf;
    vb = cfg[k].va + cfg[k].vf;
    e.col = 16'(c);
    e.row = 16'(r);
    e.hs  = (c >= hb && c < hb + cfg[k].hs) ? cfg[k].hp : ~cfg[k].hp;
    e.vs  = (r >= vb && r < vb + cfg[k].vs) ? cfg[k].vp : ~cfg[k].vp;
    e.act = (c < cfg[k].ha) && (r < cfg[k].va);
    e.ls  = m_ce[k] && (c == 0);
    e.fs  = m_ce[k] && (c == 0) && (r == 0);
    return e;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_v[k]) begin
        m_rst[k]   <= 1'b1;
        m_t[k]     <= 0;
        m_ce[k]    <= 1'b0;
        m_valid[k] <= 1'b1;
      end else begin
        m_rst[k] <= 1'b0;
        m_ce[k]  <= ce_v[k];
        if (ce_v[k]) m_t[k] <= m_t[k] + 1;
      end
    end
  end

  task automatic cmp(input int k);
    obs_t g, e;
    g = cur(k);
    e = model(k);
    chk($sformatf("m%0d.col", k), g.col, e.col);
    chk($sformatf("m%0d.row", k), g.row, e.row);
    chk($sformatf("m%0d.hsync", k), g.hs, e.hs);
    chk($sformatf("m%0d.vsync", k), g.vs, e.vs);
    chk($sformatf("m%0d.active", k), g.act, e.act);
    chk($sformatf("m%0d.line_start", k), g.ls, e.ls);
    chk($sformatf("m%0d.frame_start", k), g.fs, e.fs);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (m_valid[k]) cmp(k);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int k, input int r, input int c, input int lim, input string nm);
    int i;
    i = 0;
    while (!(cur(k).row == 16'(r) && cur(k).col == 16'(c)) && i < lim) begin
      step();
      i++;
    end
    chk({nm, ".reached"}, {31'd0, (cur(k).row == 16'(r) && cur(k).col == 16'(c))}, 1);
  endtask

  // Cycles from now until the next pulse on line_start (fs=0) or frame_start (fs=1)
  task automatic wait_ev(input int k, input bit fs, input int lim, input string nm, output int n);
    obs_t o;
    n = 0;
    for (int i = 1; i <= lim; i++) begin
      step();
      o = cur(k);
      if (fs ? o.fs : o.ls) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk({nm, ".timeout"}, 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hlow, hfirst, vlow;
    int last0, per0, last1, per1, lastf1, perf1, dbl;
    bit prev0, prev1;

    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg[1] = '{8, 2, 3, 1, 4, 1, 1, 1, 1'b1, 1'b1};
    cfg[2] = '{6, 0, 2, 2, 3, 1, 0, 1, 1'b0, 1'b0};
    rst_v = 3'b111;
    ce_v  = 3'b111;

    step();
    chk("rst.col", d0_col, 0);
    chk("rst.row", d0_row, 0);
    chk("rst.hsync", d0_hs, 1);
    chk("rst.vsync", d0_vs, 1);
    chk("rst.active", d0_act, 1);
    chk("rst.line_start", d0_ls, 0);
    chk("rst.frame_start", d0_fs, 0);
    chk("rst.small_hsync", d1_hs, 0);
    chk("rst.small_vsync", d1_vs, 0);
    rst_v = 3'b000;
    step();
    chk("rel.col", d0_col, 1);
    chk("rel.small_col", d1_col, 1);

    // Default timing: line period and hsync window
    wait_ev(0, 1'b0, 1000, "def.first_line", n);
    chk("def.first_line_edge", n, 799);
    hlow = 0;
    hfirst = -1;
    n = 0;
    for (int i = 1; i <= 2000; i++) begin
      step();
      if (!d0_hs) begin
        hlow++;
        if (hfirst < 0) hfirst = int'(d0_col);
      end
      if (d0_ls) begin
        n = i;
        break;
      end
    end
    chk("def.line_period", n, 800);
    chk("def.hsync_width", hlow, 96);
    chk("def.hsync_first_col", hfirst, 656);
    chk("def.row_after_two_lines", d0_row, 2);

    // Small config: frame period and sync windows
    wait_ev(1, 1'b1, 200, "small.fs_a", n);
    wait_ev(1, 1'b1, 200, "small.fs_b", n);
    chk("small.frame_period", n, 98);
    wait_pos(1, 3, 7, 200, "small.last_active");
    chk("small.act_3_7", d1_act, 1);
    step();
    chk("small.col_3_8", d1_col, 8);
    chk("small.act_3_8", d1_act, 0);
    wait_pos(1, 4, 13, 200, "small.pre_vs");
    chk("small.vs_4_13", d1_vs, 0);
    step();
    chk("small.vs_5_0", d1_vs, 1);
    chk("small.hs_5_0", d1_hs, 0);
    wait_pos(1, 5, 13, 200, "small.vs_end");
    chk("small.vs_5_13", d1_vs, 1);
    step();
    chk("small.vs_6_0", d1_vs, 0);
    wait_pos(1, 6, 9, 200, "small.pre_hs");
    chk("small.hs_6_9", d1_hs, 0);
    step();
    chk("small.hs_6_10", d1_hs, 1);
    wait_pos(1, 6, 12, 200, "small.hs_end");
    chk("small.hs_6_12", d1_hs, 1);
    step();
    chk("small.hs_6_13", d1_hs, 0);
    wait_pos(1, 0, 0, 200, "small.wrap");
    chk("small.wrap_ls", d1_ls, 1);
    chk("small.wrap_fs", d1_fs, 1);
    chk("small.wrap_act", d1_act, 1);

    // Reset in the middle of a frame with ce held high
    wait_pos(1, 4, 5, 200, "small.rst_point");
    rst_v[1] = 1'b1;
    step();
    chk("mid_rst.col", d1_col, 0);
    chk("mid_rst.row", d1_row, 0);
    chk("mid_rst.fs", d1_fs, 0);
    chk("mid_rst.ls", d1_ls, 0);
    chk("mid_rst.hs", d1_hs, 0);
    chk("mid_rst.vs", d1_vs, 0);
    rst_v[1] = 1'b0;
    step();
    chk("mid_rel.col", d1_col, 1);
    chk("mid_rel.row", d1_row, 0);
    step();
    chk("mid_rel.col2", d1_col, 2);

    // Zero-width vsync and front porch
    vlow = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!d2_vs) vlow++;
    end
    chk("zero.vsync_low_cycles", vlow, 0);
    wait_pos(2, 1, 5, 100, "zero.last_active");
    chk("zero.act_1_5", d2_act, 1);
    chk("zero.hs_1_5", d2_hs, 1);
    step();
    chk("zero.hs_1_6", d2_hs, 0);
    chk("zero.act_1_6", d2_act, 0);

    // ce on every 4th clk for default and small configs
    last0 = -1; per0 = 0; last1 = -1; per1 = 0; lastf1 = -1; perf1 = 0;
    dbl = 0; prev0 = 1'b0; prev1 = 1'b0;
    for (int i = 0; i < 7000; i++) begin
      ce_v[0] = (i % 4 == 0);
      ce_v[1] = (i % 4 == 0);
      step();
      if (d0_ls) begin
        if (prev0) dbl++;
        if (last0 >= 0) per0 = i - last0;
        last0 = i;
      end
      if (d1_ls) begin
        if (prev1) dbl++;
        if (last1 >= 0) per1 = i - last1;
        last1 = i;
      end
      if (d1_fs) begin
        if (lastf1 >= 0) perf1 = i - lastf1;
        lastf1 = i;
      end
      prev0 = d0_ls;
      prev1 = d1_ls;
    end
    chk("ce4.def_line_period", per0, 3200);
    chk("ce4.small_line_period", per1, 56);
    chk("ce4.small_frame_period", perf1, 392);
    chk("ce4.ls_wide_pulses", dbl, 0);
    ce_v = 3'b111;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
